// File: rtl/voice_sched.sv
// voice_sched: keyboard-to-voice scheduler.
//   Synchronises and debounces raw key levels, turns debounced edges into
//   pending press/release events and services them one key at a time with a
//   scan FSM that assigns or frees NUM_VOICES synthesis voice slots.
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   teclado         raw asynchronous key levels (1 = pressed)
//   voice_key       key index per voice, voice v at [v*KEY_W +: KEY_W]
//   voice_active    voice v currently holds a key
//   voice_trig      one-cycle pulse when voice v receives a new key
//   stable_keys     debounced key levels
//   overflow        sticky: a press found no free voice (cleared by ovf_clr)
//   ovf_clr         clears overflow (a coincident set wins)
// Optional build macro:
//   VOICE_STEAL_EN  when defined, a press with no free voice steals the
//                   oldest voice instead of being dropped.
module voice_sched #(
   parameter int NUM_KEYS        = 11,
   parameter int NUM_VOICES      = 4,
   parameter int KEY_W           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_KEYS-1:0]         teclado,
   output logic [NUM_VOICES*KEY_W-1:0] voice_key,
   output logic [NUM_VOICES-1:0]       voice_active,
   output logic [NUM_VOICES-1:0]       voice_trig,
   output logic [NUM_KEYS-1:0]         stable_keys,
   output logic                        overflow,
   input  logic                        ovf_clr
);

   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int VIDX_W = $clog2(NUM_VOICES);
   localparam logic [VIDX_W-1:0] AGE_MAX  = VIDX_W'(NUM_VOICES - 1);
   localparam logic [KEY_W-1:0]  KEY_LAST = KEY_W'(NUM_KEYS - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SCAN, REL, ALLOC} state_t;

   logic [NUM_KEYS-1:0] sync_meta, sync, samp;
   logic [NUM_KEYS-1:0] pend_press, pend_rel;
   logic [NUM_KEYS-1:0] upd, rise, fall, key_sel, clr_press, clr_rel;
   logic [CNT_W-1:0]    tick_cnt;
   logic                tick, pend_any;
   state_t              state, state_nxt;
   logic [KEY_W-1:0]    k, k_nxt;
   logic                do_rel, do_alloc;
   logic [VIDX_W-1:0]   age [NUM_VOICES];
   logic                hit, free_found, tgt_en, ovf_set;
   logic [VIDX_W-1:0]   free_idx, tgt_idx;

   assign tick     = (tick_cnt == CNT_LAST);
   // A key updates only when the previous tick's sample agrees with now.
   assign upd      = tick ? (~(sync ^ samp) & (sync ^ stable_keys)) : {NUM_KEYS{1'b0}};
   assign rise     = upd & sync;
   assign fall     = upd & ~sync;
   assign key_sel  = {{(NUM_KEYS-1){1'b0}}, 1'b1} << k;
   assign clr_press = do_alloc ? key_sel : {NUM_KEYS{1'b0}};
   assign clr_rel   = do_rel   ? key_sel : {NUM_KEYS{1'b0}};
   assign pend_any  = (|pend_press) | (|pend_rel);

   // Input synchroniser, debounce sampler and pending-event bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta   <= '0;
         sync        <= '0;
         samp        <= '0;
         tick_cnt    <= '0;
         stable_keys <= '0;
         pend_press  <= '0;
         pend_rel    <= '0;
      end else begin
         sync_meta   <= teclado;
         sync        <= sync_meta;
         tick_cnt    <= tick ? {CNT_W{1'b0}} : tick_cnt + 1'b1;
         samp        <= tick ? sync : samp;
         stable_keys <= (stable_keys & ~fall) | rise;
         // New events win over a coincident service clear.
         pend_press  <= (pend_press & ~clr_press) | rise;
         pend_rel    <= (pend_rel & ~clr_rel) | fall;
      end
   end

   // FSM state and scan pointer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         k     <= '0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
      end
   end

   // FSM next-state and scan pointer logic.
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      case (state)
         IDLE: begin
            if (pend_any) begin
               state_nxt = SCAN;
               k_nxt     = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
         SCAN: begin
            if (pend_rel[k]) begin
               state_nxt = REL;
            end else if (pend_press[k]) begin
               state_nxt = ALLOC;
            end else if (k == KEY_LAST) begin
               k_nxt     = '0;
               state_nxt = pend_any ? SCAN : IDLE;
            end else begin
               k_nxt = k + 1'b1;
            end
         end
         // k is kept so a press of the same key is serviced right after.
         REL:   state_nxt = SCAN;
         ALLOC: begin
            state_nxt = SCAN;
            k_nxt     = (k == KEY_LAST) ? {KEY_W{1'b0}} : k + 1'b1;
         end
         default: begin
            state_nxt = IDLE;
            k_nxt     = '0;
         end
      endcase
   end

   // FSM action strobes.
   always_comb begin
      do_rel   = 1'b0;
      do_alloc = 1'b0;
      case (state)
         REL:     do_rel   = 1'b1;
         ALLOC:   do_alloc = 1'b1;
         default: begin
            do_rel   = 1'b0;
            do_alloc = 1'b0;
         end
      endcase
   end

   // Duplicate-key detection and lowest-index free voice search.
   always_comb begin
      hit        = 1'b0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         hit        = hit | (voice_active[v] && (voice_key[v*KEY_W +: KEY_W] == k));
         free_found = free_found | ~voice_active[v];
         free_idx   = voice_active[v] ? free_idx : VIDX_W'(v);
      end
   end

`ifdef VOICE_STEAL_EN
   logic [VIDX_W-1:0] victim_idx, victim_age;

   // Oldest voice; descending scan with >= keeps the lowest index on a tie.
   always_comb begin
      victim_idx = '0;
      victim_age = '0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         victim_idx = (age[v] >= victim_age) ? VIDX_W'(v) : victim_idx;
         victim_age = (age[v] >= victim_age) ? age[v] : victim_age;
      end
   end

   assign tgt_idx = free_found ? free_idx : victim_idx;
   assign tgt_en  = do_alloc && !hit;
`else
   assign tgt_idx = free_idx;
   assign tgt_en  = do_alloc && !hit && free_found;
`endif

   assign ovf_set = do_alloc && !hit && !free_found;

   // Voice slot state, ages, trigger pulses and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         voice_key    <= '0;
         voice_active <= '0;
         voice_trig   <= '0;
         overflow     <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            age[v] <= '0;
         end
      end else begin
         voice_trig <= '0;
         overflow   <= ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : overflow);
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (tgt_en) begin
               if (tgt_idx == VIDX_W'(v)) begin
                  voice_key[v*KEY_W +: KEY_W] <= k;
                  voice_active[v]             <= 1'b1;
                  voice_trig[v]               <= 1'b1;
                  age[v]                      <= '0;
               end else if (voice_active[v] && (age[v] != AGE_MAX)) begin
                  age[v] <= age[v] + 1'b1;
               end else begin
                  age[v] <= age[v];
               end
            end else if (do_rel && voice_active[v] &&
                         (voice_key[v*KEY_W +: KEY_W] == k)) begin
               voice_active[v] <= 1'b0;
            end else begin
               voice_active[v] <= voice_active[v];
            end
         end
      end
   end

endmodule

// File: tb/tb_voice_sched.sv
// Self-checking bench for voice_sched (DEBOUNCE_CYCLES=4). Expected voice
// trigger events are queued when keys are driven and compared by a monitor
// whenever voice_trig pulses.
module tb_voice_sched;

   localparam int NK = 11;
   localparam int NV = 4;
   localparam int KW = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ovf_clr = 1'b0;
   logic [NK-1:0]     teclado = '0;
   logic [NV*KW-1:0]  voice_key;
   logic [NV-1:0]     voice_active;
   logic [NV-1:0]     voice_trig;
   logic [NK-1:0]     stable_keys;
   logic              overflow;

   int                n_checks = 0;
   int                n_fail = 0;
   logic [7:0]        exp_q[$];
   logic [7:0]        mon_e;
   int unsigned       cyc;

   always #5 clk = ~clk;

   voice_sched #(
      .NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk), .reset(reset), .teclado(teclado),
      .voice_key(voice_key), .voice_active(voice_active),
      .voice_trig(voice_trig), .stable_keys(stable_keys),
      .overflow(overflow), .ovf_clr(ovf_clr)
   );

   // Edge count since reset release, used to phase the bounce stimulus.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] vkey(input int v);
      return 32'(voice_key[v*KW +: KW]);
   endfunction

   task automatic push_exp(input int v, input int key);
      exp_q.push_back({4'(v), 4'(key)});
   endtask

   // Scoreboard: every trigger pulse must match the next queued event.
   always @(negedge clk) begin
      if (!reset && (voice_trig != '0)) begin
         if (exp_q.size() == 0) begin
            check("trig_unexpected", 32'(voice_trig), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("trig_voice", 32'(voice_trig), 32'd1 << mon_e[7:4]);
            check("trig_key", 32'(voice_key[mon_e[7:4]*KW +: KW]), 32'(mon_e[3:0]));
         end
      end
   end

   task automatic do_reset(input logic [NK-1:0] keys);
      @(negedge clk);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      reset   = 1'b1;
      ovf_clr = 1'b0;
      teclado = keys;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_voice_key", 32'(voice_key), 32'd0);
      check("rst_active", 32'(voice_active), 32'd0);
      check("rst_trig", 32'(voice_trig), 32'd0);
      check("rst_stable", 32'(stable_keys), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      reset = 1'b0;
   endtask

   task automatic settle();
      repeat (60) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int w;

      // Reset with every key held, then allocation of the first keys.
      do_reset(11'h7FF);
      push_exp(0, 0); push_exp(1, 1); push_exp(2, 2); push_exp(3, 3);
`ifdef VOICE_STEAL_EN
      push_exp(0, 4); push_exp(1, 5); push_exp(2, 6); push_exp(3, 7);
      push_exp(0, 8); push_exp(1, 9); push_exp(2, 10);
`endif
      w = 0;
      while ((stable_keys !== 11'h7FF) && (w < 12)) begin
         @(negedge clk);
         w++;
      end
      check("stable_all_in_12", 32'(stable_keys), 32'h7FF);
      settle();
      check("all_active", 32'(voice_active), 32'hF);
      check("all_overflow", 32'(overflow), 32'd1);
`ifdef VOICE_STEAL_EN
      check("all_v0", vkey(0), 32'd8);  check("all_v1", vkey(1), 32'd9);
      check("all_v2", vkey(2), 32'd10); check("all_v3", vkey(3), 32'd7);
`else
      check("all_v0", vkey(0), 32'd0);  check("all_v1", vkey(1), 32'd1);
      check("all_v2", vkey(2), 32'd2);  check("all_v3", vkey(3), 32'd3);
`endif

      // Bounce: key 5 toggles every cycle, low on the cycles the debounce
      // samples land on, so it must never be accepted.
      do_reset(11'h000);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         teclado[5] = ~cyc[0];
      end
      @(negedge clk);
      check("bounce_no_stable", 32'(stable_keys), 32'd0);
      teclado[5] = 1'b1;
      push_exp(0, 5);
      settle();
      check("bounce_stable5", 32'(stable_keys[5]), 32'd1);
      check("bounce_v0_key", vkey(0), 32'd5);
      check("bounce_active", 32'(voice_active), 32'h1);

      // Release and reuse of the lowest free voice.
      do_reset(11'h000);
      teclado[2] = 1'b1;
      teclado[7] = 1'b1;
      push_exp(0, 2); push_exp(1, 7);
      settle();
      teclado[2] = 1'b0;
      settle();
      check("rel_active", 32'(voice_active), 32'h2);
      check("rel_key_held", vkey(0), 32'd2);
      teclado[9] = 1'b1;
      push_exp(0, 9);
      settle();
      check("reuse_active", 32'(voice_active), 32'h3);
      check("reuse_v0_key", vkey(0), 32'd9);
      check("reuse_v1_key", vkey(1), 32'd7);

      // Full voice table, then one more press.
      do_reset(11'h000);
      for (int key = 1; key <= 4; key++) begin
         teclado[key] = 1'b1;
         push_exp(key - 1, key);
         settle();
      end
      check("full_no_ovf", 32'(overflow), 32'd0);
      teclado[6] = 1'b1;
`ifdef VOICE_STEAL_EN
      push_exp(0, 6);
`endif
      settle();
      check("full_overflow", 32'(overflow), 32'd1);
      check("full_active", 32'(voice_active), 32'hF);
`ifdef VOICE_STEAL_EN
      check("full_v0", vkey(0), 32'd6);
`else
      check("full_v0", vkey(0), 32'd1);
`endif
      check("full_v1", vkey(1), 32'd2);
      check("full_v2", vkey(2), 32'd3);
      check("full_v3", vkey(3), 32'd4);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check("ovf_clr", 32'(overflow), 32'd0);

      // Release of key 3 and press of key 8 in the same debounce window.
      do_reset(11'h000);
      teclado[1] = 1'b1;
      teclado[3] = 1'b1;
      push_exp(0, 1); push_exp(1, 3);
      settle();
      teclado[3] = 1'b0;
      teclado[8] = 1'b1;
      push_exp(1, 8);
      settle();
      check("swap_active", 32'(voice_active), 32'h3);
      check("swap_v1_key", vkey(1), 32'd8);
      check("swap_stable", 32'(stable_keys), 32'h102);
      check("swap_overflow", 32'(overflow), 32'd0);

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
